// File: rtl/rx_ber_checker.sv
// rx_ber_checker: decimates a 4x stream, slices to bits, searches the reference delay, then counts bits/errors.
// Latency: 1 cycle from decision strobe to o_rx_bit/o_bit_valid/counters/o_delay/o_locked; no backpressure, paced by i_EnbRx.
// RX_BER_AUTO_RELOCK_EN: when defined, LOCK keeps monitoring windows and falls back to SEARCH on excess errors.
module rx_ber_checker #(
   parameter int NB_INPUT  = 12,
   parameter int N_DELAY   = 512,
   parameter int NB_DLY    = 9,
   parameter int WINDOW    = 511,
   parameter int NB_CNT    = 32,
   parameter int RELOCK_TH = 16
) (
   input  logic                       clk,
   input  logic                       i_rst,
   input  logic                       i_EnbRx,
   input  logic signed [NB_INPUT-1:0] i_rx_data,
   input  logic        [1:0]          i_phase_sel,
   input  logic                       i_ref_bit,
   output logic                       o_rx_bit,
   output logic                       o_bit_valid,
   output logic                       o_locked,
   output logic        [NB_DLY-1:0]   o_delay,
   output logic        [NB_CNT-1:0]   o_bit_count,
   output logic        [NB_CNT-1:0]   o_err_count
);

   localparam int NB_WIN = $clog2(WINDOW + 1);
   localparam int NB_WT  = NB_WIN + 1;

`ifdef RX_BER_AUTO_RELOCK_EN
   localparam bit AUTO_RELOCK = 1'b1;
`else
   localparam bit AUTO_RELOCK = 1'b0;
`endif

   typedef enum logic {ST_SEARCH, ST_LOCK} state_t;

   state_t              state, state_nxt;
   logic [1:0]          phase_cnt;
   logic [N_DELAY-2:0]  ref_sr;
   logic [N_DELAY-1:0]  cmp_vec;
   logic [NB_WIN-1:0]   win_cnt;
   logic [NB_WIN-1:0]   win_err;
   logic [NB_WT-1:0]    win_total;
   logic                strobe;
   logic                rx_now;
   logic                err_now;
   logic                win_end;
   logic                win_run;
   logic                delay_inc;
   logic                cnt_sat;

   assign strobe    = i_EnbRx && (phase_cnt == i_phase_sel);
   assign rx_now    = i_rx_data[NB_INPUT-1];
   // Bit 0 is the reference arriving with this decision, bit d the one d strobes older.
   assign cmp_vec   = {ref_sr, i_ref_bit};
   assign err_now   = rx_now ^ cmp_vec[o_delay];
   assign win_end   = (win_cnt == NB_WIN'(WINDOW - 1));
   assign win_total = {1'b0, win_err} + NB_WT'(err_now);
   assign cnt_sat   = &o_bit_count;
   assign o_locked  = (state == ST_LOCK);

   always_comb begin
      state_nxt = state;
      win_run   = 1'b0;
      delay_inc = 1'b0;
      case (state)
         ST_SEARCH: begin
            win_run = strobe;
            if (strobe && win_end) begin
               if (win_total == '0) begin
                  state_nxt = ST_LOCK;
               end else begin
                  delay_inc = 1'b1;
               end
            end
         end
         ST_LOCK: begin
            win_run = strobe && AUTO_RELOCK;
            if (AUTO_RELOCK && strobe && win_end && (win_total > NB_WT'(RELOCK_TH))) begin
               state_nxt = ST_SEARCH;
               delay_inc = 1'b1;
            end
         end
         default: state_nxt = ST_SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state       <= ST_SEARCH;
         phase_cnt   <= '0;
         ref_sr      <= '0;
         win_cnt     <= '0;
         win_err     <= '0;
         o_rx_bit    <= 1'b0;
         o_bit_valid <= 1'b0;
         o_delay     <= '0;
         o_bit_count <= '0;
         o_err_count <= '0;
      end else begin
         state       <= state_nxt;
         o_bit_valid <= strobe;
         if (i_EnbRx) begin
            phase_cnt <= phase_cnt + 2'd1;
         end
         if (strobe) begin
            o_rx_bit <= rx_now;
            ref_sr   <= cmp_vec[N_DELAY-2:0];
            if (win_run) begin
               if (win_end) begin
                  win_cnt <= '0;
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + NB_WIN'(1);
                  win_err <= win_total[NB_WIN-1:0];
               end
            end
            if (delay_inc) begin
               o_delay <= (o_delay == NB_DLY'(N_DELAY - 1)) ? '0 : o_delay + NB_DLY'(1);
            end
            // Saturation of the bit counter freezes both statistics together.
            if ((state == ST_LOCK) && !cnt_sat) begin
               o_bit_count <= o_bit_count + NB_CNT'(1);
               if (err_now && !(&o_err_count)) begin
                  o_err_count <= o_err_count + NB_CNT'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: random-stimulus scenarios checked against a per-strobe behavioural model.
// A second instance with 4-bit counters exercises saturation on the same stimulus.
module tb_rx_ber_checker;

   localparam int NB_INPUT  = 12;
   localparam int N_DELAY   = 64;
   localparam int NB_DLY    = 6;
   localparam int WINDOW    = 63;
   localparam int NB_CNT    = 32;
   localparam int NB_CNT_S  = 4;
   localparam int RELOCK_TH = 16;
   localparam int N_PR      = 8192;

`ifdef RX_BER_AUTO_RELOCK_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       i_rst = 1'b1;
   logic                       i_EnbRx = 1'b0;
   logic signed [NB_INPUT-1:0] i_rx_data = '0;
   logic        [1:0]          i_phase_sel = '0;
   logic                       i_ref_bit = 1'b0;

   logic                a_rx_bit, a_vld, a_locked;
   logic [NB_DLY-1:0]   a_delay;
   logic [NB_CNT-1:0]   a_bc, a_ec;
   logic                b_rx_bit, b_vld, b_locked;
   logic [NB_DLY-1:0]   b_delay;
   logic [NB_CNT_S-1:0] b_bc, b_ec;

   rx_ber_checker #(.NB_INPUT(NB_INPUT), .N_DELAY(N_DELAY), .NB_DLY(NB_DLY), .WINDOW(WINDOW),
                    .NB_CNT(NB_CNT), .RELOCK_TH(RELOCK_TH)) dut_a (
      .clk(clk), .i_rst(i_rst), .i_EnbRx(i_EnbRx), .i_rx_data(i_rx_data),
      .i_phase_sel(i_phase_sel), .i_ref_bit(i_ref_bit),
      .o_rx_bit(a_rx_bit), .o_bit_valid(a_vld), .o_locked(a_locked), .o_delay(a_delay),
      .o_bit_count(a_bc), .o_err_count(a_ec));

   rx_ber_checker #(.NB_INPUT(NB_INPUT), .N_DELAY(N_DELAY), .NB_DLY(NB_DLY), .WINDOW(WINDOW),
                    .NB_CNT(NB_CNT_S), .RELOCK_TH(RELOCK_TH)) dut_b (
      .clk(clk), .i_rst(i_rst), .i_EnbRx(i_EnbRx), .i_rx_data(i_rx_data),
      .i_phase_sel(i_phase_sel), .i_ref_bit(i_ref_bit),
      .o_rx_bit(b_rx_bit), .o_bit_valid(b_vld), .o_locked(b_locked), .o_delay(b_delay),
      .o_bit_count(b_bc), .o_err_count(b_ec));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: strobe history kept as a plain list of reference bits.
   int     m_pcnt, m_j, m_win_idx, m_win_err, m_delay;
   bit     m_locked, m_vld, m_rx_bit;
   longint m_bc, m_ec, m_bc4, m_ec4;
   bit     refh[$];
   bit     pr[N_PR];

   function automatic bit model_cmp(input int d, input bit rbit);
      if (d == 0) return rbit;
      if (refh.size() < d) return 1'b0;
      return refh[refh.size() - d];
   endfunction

   task automatic model_clear();
      m_pcnt = 0; m_j = 0; m_win_idx = 0; m_win_err = 0; m_delay = 0;
      m_locked = 0; m_vld = 0; m_rx_bit = 0;
      m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
      refh.delete();
   endtask

   task automatic step(input bit enb, input int sample, input bit rbit);
      bit strobe, rx, err, was_locked;
      @(negedge clk);
      i_EnbRx   = enb;
      i_rx_data = sample[NB_INPUT-1:0];
      i_ref_bit = rbit;
      strobe = enb && ((m_pcnt % 4) == int'(i_phase_sel));
      if (enb) m_pcnt++;
      m_vld = strobe;
      if (strobe) begin
         rx  = (sample < 0);
         err = rx ^ model_cmp(m_delay, rbit);
         refh.push_back(rbit);
         m_rx_bit = rx;
         m_j++;
         was_locked = m_locked;
         if (was_locked) begin
            if (m_bc < 64'hFFFF_FFFF) begin
               m_bc++;
               if (err && m_ec < 64'hFFFF_FFFF) m_ec++;
            end
            if (m_bc4 < 15) begin
               m_bc4++;
               if (err && m_ec4 < 15) m_ec4++;
            end
         end
         if (!was_locked || AUTO) begin
            m_win_err += int'(err);
            if (m_win_idx == WINDOW - 1) begin
               if (!was_locked && m_win_err == 0) begin
                  m_locked = 1;
               end else if (!was_locked || m_win_err > RELOCK_TH) begin
                  m_locked = 0;
                  m_delay  = (m_delay + 1) % N_DELAY;
               end
               m_win_idx = 0;
               m_win_err = 0;
            end else begin
               m_win_idx++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic int mk_sample(input bit b);
      if (b) return -int'($urandom_range(2048, 1));
      if ($urandom_range(7) == 0) return 0;
      return int'($urandom_range(2047, 1));
   endfunction

   // One symbol: random idle gaps and filler samples until the decision strobe is taken.
   task automatic send_symbol(input bit rbit, input bit rxb);
      bit enb, will;
      for (int n = 0; n < 64; n++) begin
         enb  = ($urandom_range(3) != 0);
         will = enb && ((m_pcnt % 4) == int'(i_phase_sel));
         if (will) begin
            step(enb, mk_sample(rxb), rbit);
            break;
         end
         step(enb, int'($urandom_range(4095)) - 2048, bit'($urandom_range(1)));
      end
   endtask

   task automatic send_strobe(input int dly, input bit flip);
      int j;
      bit rxb;
      j   = m_j % N_PR;
      rxb = (j >= dly) ? pr[j - dly] : bit'($urandom_range(1));
      send_symbol(pr[j], rxb ^ flip);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      i_rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         i_EnbRx     = bit'($urandom_range(1));
         i_rx_data   = NB_INPUT'($urandom);
         i_phase_sel = 2'($urandom);
         i_ref_bit   = bit'($urandom_range(1));
         @(posedge clk);
         #1;
      end
      i_rst   = 1'b0;
      i_EnbRx = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      apply_reset();
      total += 14;
      if (a_rx_bit !== 1'b0) begin bad++; $display("FAIL reset_rx_bit: got %0d want 0", a_rx_bit); end
      if (a_vld !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0d want 0", a_vld); end
      if (a_locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0d want 0", a_locked); end
      if (a_delay !== '0) begin bad++; $display("FAIL reset_delay: got %0d want 0", a_delay); end
      if (a_bc !== '0) begin bad++; $display("FAIL reset_bit_count: got %0d want 0", a_bc); end
      if (a_ec !== '0) begin bad++; $display("FAIL reset_err_count: got %0d want 0", a_ec); end
      if (b_rx_bit !== 1'b0) begin bad++; $display("FAIL reset_b_rx_bit: got %0d want 0", b_rx_bit); end
      if (b_vld !== 1'b0) begin bad++; $display("FAIL reset_b_valid: got %0d want 0", b_vld); end
      if (b_locked !== 1'b0) begin bad++; $display("FAIL reset_b_locked: got %0d want 0", b_locked); end
      if (b_delay !== '0) begin bad++; $display("FAIL reset_b_delay: got %0d want 0", b_delay); end
      if (b_bc !== '0) begin bad++; $display("FAIL reset_b_bit_count: got %0d want 0", b_bc); end
      if (b_ec !== '0) begin bad++; $display("FAIL reset_b_err_count: got %0d want 0", b_ec); end
      // Phase counter must restart at 0: with phase 0 and continuous enable the first sample strobes.
      i_phase_sel = 2'd0;
      step(1'b1, -5, 1'b0);
      if (a_vld !== 1'b1) begin bad++; $display("FAIL reset_phase_first: got %0d want 1", a_vld); end
      step(1'b1, -5, 1'b0);
      if (a_vld !== 1'b0) begin bad++; $display("FAIL reset_phase_second: got %0d want 0", a_vld); end
   endtask

   task automatic test_decimation();
      int  v;
      bit  exp_vld;
      apply_reset();
      i_phase_sel = 2'd2;
      for (int i = 0; i < 16; i++) begin
         v = (i % 4 == 2) ? -100 : 100;
         step(1'b1, v, bit'($urandom_range(1)));
         exp_vld = (i % 4 == 2);
         total++;
         if (a_vld !== exp_vld) begin bad++; $display("FAIL decim_valid[%0d]: got %0d want %0d", i, a_vld, exp_vld); end
         if (exp_vld) begin
            total++;
            if (a_rx_bit !== 1'b1) begin bad++; $display("FAIL decim_rx_bit[%0d]: got %0d want 1", i, a_rx_bit); end
         end
      end
      // Enable low: outputs hold, no new valid.
      step(1'b0, -100, 1'b0);
      step(1'b0, -100, 1'b0);
      total += 2;
      if (a_vld !== 1'b0) begin bad++; $display("FAIL decim_hold_valid: got %0d want 0", a_vld); end
      if (a_rx_bit !== 1'b1) begin bad++; $display("FAIL decim_hold_rx_bit: got %0d want 1", a_rx_bit); end
   endtask

   task automatic test_alignment();
      apply_reset();
      i_phase_sel = 2'($urandom);
      for (int n = 0; n < 38 * WINDOW; n++) begin
         send_strobe(37, 1'b0);
         total += 3;
         if (a_locked !== m_locked) begin bad++; $display("FAIL align_locked[%0d]: got %0d want %0d", n, a_locked, m_locked); end
         if (int'(a_delay) !== m_delay) begin bad++; $display("FAIL align_delay[%0d]: got %0d want %0d", n, a_delay, m_delay); end
         if (a_rx_bit !== m_rx_bit) begin bad++; $display("FAIL align_rx_bit[%0d]: got %0d want %0d", n, a_rx_bit, m_rx_bit); end
         if (n == 38 * WINDOW - 2) begin
            total++;
            if (a_locked !== 1'b0) begin bad++; $display("FAIL align_early_lock: got %0d want 0", a_locked); end
         end
      end
      total += 3;
      if (a_locked !== 1'b1) begin bad++; $display("FAIL align_locked_final: got %0d want 1", a_locked); end
      if (a_delay !== NB_DLY'(37)) begin bad++; $display("FAIL align_delay_final: got %0d want 37", a_delay); end
      if (a_bc !== '0) begin bad++; $display("FAIL align_bit_count: got %0d want 0", a_bc); end
   endtask

   task automatic test_error_count();
      for (int n = 0; n < 1000; n++) begin
         if (n == 500) i_phase_sel = 2'($urandom);
         send_strobe(37, (n % 100) == 99);
      end
      total += 6;
      if (a_bc !== NB_CNT'(1000)) begin bad++; $display("FAIL err_bit_count: got %0d want 1000", a_bc); end
      if (a_ec !== NB_CNT'(10)) begin bad++; $display("FAIL err_err_count: got %0d want 10", a_ec); end
      if (b_bc !== 4'd15) begin bad++; $display("FAIL err_b_bit_count: got %0d want 15", b_bc); end
      if (b_ec !== 4'd0) begin bad++; $display("FAIL err_b_err_count: got %0d want 0", b_ec); end
      if (a_locked !== 1'b1) begin bad++; $display("FAIL err_locked: got %0d want 1", a_locked); end
      if (a_delay !== NB_DLY'(37)) begin bad++; $display("FAIL err_delay: got %0d want 37", a_delay); end
   endtask

   task automatic test_relock();
      bit saw_unlock = 1'b0;
      for (int n = 0; n < 8 * WINDOW; n++) begin
         send_strobe(40, 1'b0);
         if (a_locked === 1'b0) saw_unlock = 1'b1;
         total += 2;
         if (a_locked !== m_locked) begin bad++; $display("FAIL relock_locked[%0d]: got %0d want %0d", n, a_locked, m_locked); end
         if (int'(a_delay) !== m_delay) begin bad++; $display("FAIL relock_delay[%0d]: got %0d want %0d", n, a_delay, m_delay); end
      end
      total += 5;
      if (longint'(a_bc) !== m_bc) begin bad++; $display("FAIL relock_bit_count: got %0d want %0d", a_bc, m_bc); end
      if (longint'(a_ec) !== m_ec) begin bad++; $display("FAIL relock_err_count: got %0d want %0d", a_ec, m_ec); end
      if (a_locked !== 1'b1) begin bad++; $display("FAIL relock_locked_final: got %0d want 1", a_locked); end
      if (AUTO) begin
         if (a_delay !== NB_DLY'(40)) begin bad++; $display("FAIL relock_delay_final: got %0d want 40", a_delay); end
         if (saw_unlock !== 1'b1 || a_bc <= NB_CNT'(1000)) begin
            bad++; $display("FAIL relock_resume: unlock_seen=%0d bit_count=%0d want 1 and >1000", saw_unlock, a_bc);
         end
      end else begin
         if (a_delay !== NB_DLY'(37)) begin bad++; $display("FAIL relock_delay_final: got %0d want 37", a_delay); end
         if (saw_unlock || a_bc !== NB_CNT'(1000 + 8 * WINDOW) || a_ec < NB_CNT'(10 + 2 * WINDOW) || a_ec > NB_CNT'(10 + 6 * WINDOW)) begin
            bad++; $display("FAIL relock_stay: unlock_seen=%0d bits=%0d errs=%0d want 0, %0d, about half", saw_unlock, a_bc, a_ec, 1000 + 8 * WINDOW);
         end
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      i_phase_sel = 2'($urandom);
      for (int n = 0; n < WINDOW; n++) send_strobe(0, 1'b0);
      total += 2;
      if (a_locked !== 1'b1) begin bad++; $display("FAIL sat_locked: got %0d want 1", a_locked); end
      if (a_delay !== NB_DLY'(0)) begin bad++; $display("FAIL sat_delay: got %0d want 0", a_delay); end
      for (int n = 0; n < 20; n++) send_strobe(0, 1'b1);
      total += 4;
      if (b_bc !== 4'd15) begin bad++; $display("FAIL sat_b_bit_count: got %0d want 15", b_bc); end
      if (b_ec !== 4'd15) begin bad++; $display("FAIL sat_b_err_count: got %0d want 15", b_ec); end
      if (a_bc !== NB_CNT'(20)) begin bad++; $display("FAIL sat_a_bit_count: got %0d want 20", a_bc); end
      if (a_ec !== NB_CNT'(20)) begin bad++; $display("FAIL sat_a_err_count: got %0d want 20", a_ec); end
      for (int n = 0; n < 5; n++) send_strobe(0, 1'b1);
      total += 4;
      if (b_bc !== 4'd15) begin bad++; $display("FAIL sat_b_bit_frozen: got %0d want 15", b_bc); end
      if (b_ec !== 4'd15) begin bad++; $display("FAIL sat_b_err_frozen: got %0d want 15", b_ec); end
      if (longint'(b_bc) !== m_bc4) begin bad++; $display("FAIL sat_b_model: got %0d want %0d", b_bc, m_bc4); end
      if (a_ec !== NB_CNT'(25)) begin bad++; $display("FAIL sat_a_err_more: got %0d want 25", a_ec); end
   endtask

   initial begin
      bit [8:0] lfsr = 9'h1FF;
      bit       nb;
      for (int i = 0; i < N_PR; i++) begin
         nb    = lfsr[8] ^ lfsr[4];
         lfsr  = {lfsr[7:0], nb};
         pr[i] = nb;
      end
      model_clear();
      test_reset();
      test_decimation();
      test_alignment();
      test_error_count();
      test_relock();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
